// File: rtl/button_debounce_pkg.sv
// ----------------------------------------------------------------------------
// button_debounce_pkg
//   Shared defaults and board button indices for the button debouncer.
//   No ports; imported by debounce_cell, button_debounce and the bench.
// ----------------------------------------------------------------------------
package button_debounce_pkg;

   localparam int DEF_NUM_BTN = 5;   // independent button channels
   localparam int DEF_DEPTH   = 4;   // equal slow samples needed (>= 2)

   // Board button positions within btn_in / btn_level / btn_press / btn_release
   localparam int BTN_UP     = 0;
   localparam int BTN_DOWN   = 1;
   localparam int BTN_LEFT   = 2;
   localparam int BTN_RIGHT  = 3;
   localparam int BTN_CENTER = 4;

endpackage

// File: rtl/debounce_cell.sv
// ----------------------------------------------------------------------------
// debounce_cell
//   One debounced button channel: 2-flop input synchronizer, DEPTH-deep
//   sample history advanced only on i_strobe, registered level, and
//   one-cycle press/release pulses aligned with the level change.
//
//   Ports
//     clk        system clock, rising edge
//     rst        asynchronous, active-high reset
//     i_strobe   one-cycle sample enable derived from the slow clock
//     i_btn      raw asynchronous button input, active-high
//     o_level    debounced level
//     o_press    one-cycle pulse when o_level rises
//     o_release  one-cycle pulse when o_level falls
// ----------------------------------------------------------------------------
module debounce_cell
   import button_debounce_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic clk,
   input  logic rst,
   input  logic i_strobe,
   input  logic i_btn,
   output logic o_level,
   output logic o_press,
   output logic o_release
);

   logic             r_b1;
   logic             r_b2;
   logic [DEPTH-1:0] r_sh;
   logic             r_level;
   logic             r_press;
   logic             r_release;
   logic             w_next_level;

   // The level only moves once the whole history agrees; any mix holds it,
   // which is what rejects single-sample glitches and alternating bounce.
   always_comb begin
      // NOTE: default assignment first, so no path leaves w_next_level unassigned and no latch is inferred.
      w_next_level = r_level;
      if (&r_sh) begin
         w_next_level = 1'b1;
      end else if (~|r_sh) begin
         w_next_level = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_b1      <= 1'b0;
         r_b2      <= 1'b0;
         // NOTE: the sample history is reset too, so a reset discards any half-finished debounce.
         r_sh      <= '0;
         r_level   <= 1'b0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
      end else begin
         r_b1      <= i_btn;
         r_b2      <= r_b1;
         if (i_strobe) begin
            r_sh <= {r_sh[DEPTH-2:0], r_b2};
         end
         r_level   <= w_next_level;
         // Pulses are registered with the level so they appear in the same
         // cycle the new level is first visible.
         r_press   <= w_next_level & ~r_level;
         r_release <= ~w_next_level & r_level;
      end
   end

   assign o_level   = r_level;
   assign o_press   = r_press;
   assign o_release = r_release;

endmodule

// File: rtl/button_debounce.sv
// ----------------------------------------------------------------------------
// button_debounce
//   Debounces NUM_BTN push buttons using the divided slow clock purely as a
//   sampling strobe (edge-detected in the clk domain, never used as a clock).
//
//   Ports
//     clk          system clock, rising edge
//     rst          asynchronous, active-high reset
//     clk_slow     divided clock from the clock divider (sampling reference)
//     btn_in       raw asynchronous bouncing buttons, active-high
//     btn_level    debounced level per button
//     btn_press    one-clk pulse when btn_level rises
//     btn_release  one-clk pulse when btn_level falls
// ----------------------------------------------------------------------------
module button_debounce
   import button_debounce_pkg::*;
#(
   parameter int NUM_BTN = DEF_NUM_BTN,
   parameter int DEPTH   = DEF_DEPTH     // must be >= 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clk_slow,
   input  logic [NUM_BTN-1:0] btn_in,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [NUM_BTN-1:0] btn_release
);

   logic r_s1;
   logic r_s2;
   logic r_s3;
   logic w_strobe;

   // s1/s2 synchronize clk_slow; s3 is the delayed copy for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= clk_slow;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   // One clk cycle per clk_slow rising edge, shared by every channel.
   assign w_strobe = r_s2 & ~r_s3;

   for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_cell
      debounce_cell #(
         .DEPTH (DEPTH)
      ) u_cell (
         .clk       (clk),
         .rst       (rst),
         .i_strobe  (w_strobe),
         .i_btn     (btn_in[gi]),
         .o_level   (btn_level[gi]),
         .o_press   (btn_press[gi]),
         .o_release (btn_release[gi])
      );
   end

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Consumes the slow divided clock from the clock divider (the bit-20 tap, ~47.7 Hz at 100 MHz) and uses it as a sampling strobe, not as a clock.
- Debounces NUM_BTN push-button inputs and produces a clean level plus single-cycle press/release pulses, all in the `clk` domain.
- Sits between board buttons and the game/control FSMs.

Parameters:
- NUM_BTN, 5, number of independent button channels.
- DEPTH, 4, consecutive equal slow-strobe samples required before the debounced level changes (minimum 2).

Ports:
- clk  input  1  system clock; all flops clock on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- clk_slow  input  1  divided clock from the clock divider; edge-detected only, never used as a clock.
- btn_in  input  NUM_BTN  raw, asynchronous, bouncing button inputs, active-high.
- btn_level  output  NUM_BTN  debounced level per button.
- btn_press  output  NUM_BTN  one-clk pulse when btn_level rises.
- btn_release  output  NUM_BTN  one-clk pulse when btn_level falls.

Behaviour:
- Reset (async, rst=1): all synchronizer flops, shift registers, btn_level, btn_press and btn_release go to 0 immediately.
- clk_slow synchronizer: three flops s1→s2→s3.
  - strobe = s2 & ~s3 (combinational): exactly one clk cycle per clk_slow rising edge, 2–3 clk after the edge.
- If clk_slow is already high when reset is released, one strobe fires 2 clk after release. This is accepted; it only takes a sample.
- btn_in synchronizer: two flops per bit (b1→b2). Only b2 is sampled.
- Shift register per channel, DEPTH bits:
  - On a strobe cycle: sh <= {sh[DEPTH-2:0], b2}.
  - Otherwise sh holds.
- Level update is registered, once per clk cycle:
  - sh all ones → btn_level <= 1.
  - sh all zeros → btn_level <= 0.
  - Mixed → btn_level holds.
- btn_level changes in the clk cycle after the strobe that completes DEPTH equal samples.
- Pulses, registered in the same cycle as the level update:
  - btn_press <= next_level & ~btn_level.
  - btn_release <= ~next_level & btn_level.
  - Each pulse is high for exactly one clk cycle, and is asserted in the same cycle btn_level first shows its new value.
- Boundary conditions:
  - A glitch shorter than one strobe period that is caught in a single sample produces no level change.
  - Alternating samples never change the level.
  - btn_press and btn_release are mutually exclusive per channel.
  - Channels are fully independent; simultaneous presses on several channels all pulse in the same cycle.
  - Reset asserted mid-debounce clears all history. After release, a held button needs DEPTH fresh strobes before btn_level=1.
  - A button held through reset produces a press pulse once it qualifies.
  - clk_slow held constant means no strobes, so all outputs hold.
- Latency, stable input to btn_level change: 2 clk (btn sync) + up to one strobe period, then (DEPTH-1) further strobe periods + 1 clk.

Decomposition:
- Shared package holds:
  - default NUM_BTN and DEPTH;
  - button index constants (BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT, BTN_CENTER = 0..4).
- Sub-module `debounce_cell`: one channel containing the b1/b2 synchronizer, shift register, level flop and pulse flops. It takes strobe as an input.
- The top level holds the clk_slow synchronizer/strobe and a generate loop of NUM_BTN cells.

Test Plan:
Unless noted, every test uses DEPTH=4, NUM_BTN=5, and a bench that toggles clk_slow every 8 clk (strobe period 16 clk).
1. Reset, then hold btn_in=0 → btn_level=0 and no pulses for 20 strobes. Assert rst mid-run → all outputs read 0 in the same cycle.
2. Raise btn_in[0] cleanly and hold → btn_level[0] rises 1 clk after the 4th strobe that samples 1. btn_press[0] is high for exactly 1 clk in that cycle. All other bits stay 0.
3. Bounce btn_in[1] 1/0 every 5 clk for 60 clk, then settle to 1 → no pulse during bouncing. Exactly one btn_press[1] after 4 clean samples.
4. Start with btn_level[2]=1, release the button and hold 0 → exactly one btn_release[2] pulse 4 strobes later. btn_press[2] never asserts.
5. Press btn_in[3] and btn_in[4] in the same clk → btn_press[3] and btn_press[4] assert in the same cycle.
6. Hold a button, assert rst for 3 clk, release it → btn_level goes to 0 immediately. It returns to 1, with one btn_press pulse, after 4 post-reset strobes. Separately, stop toggling clk_slow → outputs hold indefinitely.
